bp_io_split_arbiter: RTL and testbench

//  Shares one 64-bit BedRock IO command/response channel (the input side of the
//  64->32 split serializer) among num_req_p requesters.
//  - Round-robin arbitration on commands.
//  - A grant lock keeps cmd_o stable while it is backpressured.
//  - Each issued command's owner is recorded in an in-order ownership FIFO.
//  - Responses return in issue order and are steered to the owner at the FIFO head.

---
 rtl/bp_io_split_arbiter.sv | 110 +++++++++++
 tb/tb_bp_io_split_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bp_io_split_arbiter.sv
// bp_io_split_arbiter: shares one IO cmd/resp channel among num_req_p requesters
//   Commands: round-robin arbitration; the grant is locked while cmd_o is backpressured.
//   Responses: return in issue order and are steered to the owner held at the ownership FIFO head.
//   Ports:
//     clk_i, reset_n_i                              clock, async active-low reset
//     cmd_i/cmd_v_i/cmd_ready_and_o                 per-requester command channel
//     cmd_o/cmd_v_o/cmd_ready_and_i                 arbitrated command to serializer
//     resp_i/resp_v_i/resp_ready_and_o              response from serializer
//     resp_o/resp_v_o/resp_ready_and_i              response broadcast, one-hot valid to owner
//     outstanding_o                                 in-flight command count
module bp_io_split_arbiter #(
  parameter int num_req_p     = 4,
  parameter int msg_width_p   = 96,
  parameter int outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0]     cmd_i,
  input  logic [num_req_p-1:0]                 cmd_v_i,
  output logic [num_req_p-1:0]                 cmd_ready_and_o,
  output logic [msg_width_p-1:0]               cmd_o,
  output logic                                 cmd_v_o,
  input  logic                                 cmd_ready_and_i,
  input  logic [msg_width_p-1:0]               resp_i,
  input  logic                                 resp_v_i,
  output logic                                 resp_ready_and_o,
  output logic [msg_width_p-1:0]               resp_o,
  output logic [num_req_p-1:0]                 resp_v_o,
  input  logic [num_req_p-1:0]                 resp_ready_and_i,
  output logic [$clog2(outstanding_p+1)-1:0]   outstanding_o
);
  localparam int rw_lp = $clog2(num_req_p);
  localparam int pw_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cw_lp = $clog2(outstanding_p + 1);
  typedef enum logic {e_idle, e_lock} state_e;
  state_e state_q, state_d;
  logic [rw_lp-1:0] prio_q, prio_d, lock_q, lock_d, grant, rr_grant, idx, owner;
  logic [pw_lp-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [cw_lp-1:0] cnt_q, cnt_d;
  logic [rw_lp-1:0] own_q [outstanding_p];
  logic full, empty, cmd_hs, resp_hs, rr_found;
  // first valid requester at or after prio, wrapping
  always_comb begin
    rr_grant = prio_q;
    rr_found = 1'b0;
    idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = rw_lp'((int'(prio_q) + i) % num_req_p);
      if (!rr_found && cmd_v_i[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end
    end
  end
  assign full  = cnt_q == cw_lp'(outstanding_p);
  assign empty = cnt_q == '0;
  assign grant = (state_q == e_lock) ? lock_q : rr_grant;
  // outputs are gated by reset so they read 0 while reset is held
  assign cmd_v_o         = reset_n_i & cmd_v_i[grant] & ~full;
  assign cmd_o           = reset_n_i ? cmd_i[grant*msg_width_p +: msg_width_p] : '0;
  assign cmd_hs          = cmd_v_o & cmd_ready_and_i;
  assign cmd_ready_and_o = num_req_p'(cmd_hs) << grant;
  assign owner            = own_q[rd_q];
  assign resp_o           = resp_i;
  assign resp_ready_and_o = resp_ready_and_i[owner] & ~empty;
  assign resp_v_o         = num_req_p'(resp_v_i & ~empty) << owner;
  assign resp_hs          = resp_v_i & resp_ready_and_o;
  assign outstanding_o    = cnt_q;
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    prio_d  = prio_q;
    if (cmd_hs) prio_d = (grant == rw_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
    if (state_q == e_idle && cmd_v_o && !cmd_ready_and_i) lock_d = grant;
    state_d = cmd_hs ? e_idle
            : (state_q == e_idle && cmd_v_o) ? e_lock
            : (state_q == e_lock && !cmd_v_i[lock_q]) ? e_idle
            : state_q;
  end
  always_comb begin
    wr_d  = cmd_hs ? ((wr_q == pw_lp'(outstanding_p - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = resp_hs ? ((rd_q == pw_lp'(outstanding_p - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + cw_lp'(cmd_hs) - cw_lp'(resp_hs);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      lock_q  <= '0;
      prio_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      prio_q  <= prio_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end
  // ownership storage needs no reset: entries are only read below cnt_q
  always_ff @(posedge clk_i) begin
    if (cmd_hs) own_q[wr_q] <= grant;
  end
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(resp_v_i && empty))
    else $error("resp_v_i with no outstanding command");
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(state_q == e_lock && !cmd_v_i[lock_q]))
    else $error("locked requester dropped cmd_v_i");
endmodule

// File: tb/tb_bp_io_split_arbiter.sv
// tb_bp_io_split_arbiter: directed and random checks of bp_io_split_arbiter against a queue model
module tb_bp_io_split_arbiter;
  localparam int N = 4;
  localparam int W = 96;
  localparam int OUT = 4;
  logic clk_i, reset_n_i;
  logic [N*W-1:0] cmd_i;
  logic [N-1:0] cmd_v_i, cmd_ready_and_o, resp_v_o, resp_ready_and_i;
  logic [W-1:0] cmd_o, resp_i, resp_o;
  logic cmd_v_o, cmd_ready_and_i, resp_v_i, resp_ready_and_o;
  logic [2:0] outstanding_o;
  int checks = 0, failures = 0;
  int q[$];
  int prio = 0, lock = -1;
  logic [W-1:0] msg [N];
  logic [N-1:0] last_rdy, last_resp_v;
  logic last_cmd_v, last_resp_rdy;
  logic [2:0] last_out;
  bp_io_split_arbiter #(.num_req_p(N), .msg_width_p(W), .outstanding_p(OUT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o),
    .cmd_o(cmd_o), .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i),
    .resp_i(resp_i), .resp_v_i(resp_v_i), .resp_ready_and_o(resp_ready_and_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
    .outstanding_o(outstanding_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic bt(input logic [N-1:0] x, input int k);
    logic [N-1:0] t;
    t = x >> k;
    return t[0];
  endfunction
  task automatic cyc(input logic [N-1:0] cv, input logic crdy, input logic rv, input logic [N-1:0] rrdy);
    int g, own;
    logic v, full, empty, err;
    logic [N-1:0] er, erv;
    @(negedge clk_i);
    if (lock >= 0) cv = cv | (N'(1) << lock);
    if (q.size() == 0) rv = 1'b0;
    for (int r = 0; r < N; r++) begin
      msg[r] = {$urandom, $urandom, $urandom};
      cmd_i[r*W +: W] = msg[r];
    end
    cmd_v_i = cv;
    cmd_ready_and_i = crdy;
    resp_v_i = rv;
    resp_ready_and_i = rrdy;
    resp_i = {$urandom, $urandom, $urandom};
    #1;
    full = q.size() == OUT;
    empty = q.size() == 0;
    g = -1;
    if (lock >= 0) g = lock;
    else for (int i = 0; i < N; i++) if (g < 0 && bt(cv, (prio + i) % N)) g = (prio + i) % N;
    v = (g >= 0) && !full;
    er = (v && crdy) ? N'(1) << g : '0;
    own = empty ? 0 : q[0];
    erv = (rv && !empty) ? N'(1) << own : '0;
    err = !empty && bt(rrdy, own);
    chk("cmd_v", W'(cmd_v_o), W'(v));
    chk("cmd_rdy", W'(cmd_ready_and_o), W'(er));
    if (v) chk("cmd_o", cmd_o, msg[g]);
    chk("resp_v", W'(resp_v_o), W'(erv));
    chk("resp_rdy", W'(resp_ready_and_o), W'(err));
    chk("resp_o", resp_o, resp_i);
    chk("outstanding", W'(outstanding_o), W'(q.size()));
    last_rdy = cmd_ready_and_o;
    last_cmd_v = cmd_v_o;
    last_resp_v = resp_v_o;
    last_resp_rdy = resp_ready_and_o;
    last_out = outstanding_o;
    if (rv && err) void'(q.pop_front());
    if (v && crdy) begin
      q.push_back(g);
      prio = (g + 1) % N;
      lock = -1;
    end else if (v) lock = g;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_v"}, W'(cmd_v_o), '0);
    chk({tag, "_cmd_rdy"}, W'(cmd_ready_and_o), '0);
    chk({tag, "_cmd_o"}, cmd_o, '0);
    chk({tag, "_resp_v"}, W'(resp_v_o), '0);
    chk({tag, "_resp_rdy"}, W'(resp_ready_and_o), '0);
    chk({tag, "_outstanding"}, W'(outstanding_o), '0);
  endtask
  initial begin
    reset_n_i = 1'b0;
    cmd_v_i = '1;
    cmd_ready_and_i = 1'b1;
    resp_v_i = 1'b0;
    resp_ready_and_i = '1;
    resp_i = '0;
    for (int r = 0; r < N; r++) cmd_i[r*W +: W] = {$urandom, $urandom, $urandom};
    #12;
    chk_reset_outputs("reset");
    @(negedge clk_i);
    cmd_v_i = '0;
    reset_n_i = 1'b1;
    // round-robin order from reset, then fill to the outstanding limit
    cyc('1, 1, 0, '1); chk("t1_g0", W'(last_rdy), W'(4'b0001));
    cyc('1, 1, 0, '1); chk("t1_g1", W'(last_rdy), W'(4'b0010));
    cyc('1, 1, 0, '1); chk("t1_g2", W'(last_rdy), W'(4'b0100));
    cyc('1, 1, 0, '1); chk("t1_g3", W'(last_rdy), W'(4'b1000));
    cyc('1, 1, 0, '1); chk("t3_full_v", W'(last_cmd_v), '0); chk("t3_full_n", W'(last_out), W'(4));
    cyc('1, 1, 1, '1); chk("t3_full_deq_rdy", W'(last_rdy), '0);
    cyc('1, 1, 0, '1); chk("t3_after_n", W'(last_out), W'(3)); chk("t1_g0_again", W'(last_rdy), W'(4'b0001));
    for (int k = 0; k < 8 && q.size() > 0; k++) cyc('0, 0, 1, '1);
    // grant lock under backpressure
    cyc(4'b0100, 0, 0, '0); chk("t2_lock0", W'(last_rdy), '0);
    cyc(4'b0101, 0, 0, '0); chk("t2_lock1", W'(last_cmd_v), W'(1));
    cyc(4'b0101, 0, 0, '0); chk("t2_lock2", W'(last_rdy), '0);
    cyc(4'b0101, 1, 0, '0); chk("t2_hs2", W'(last_rdy), W'(4'b0100));
    cyc(4'b0001, 1, 0, '0); chk("t2_hs0", W'(last_rdy), W'(4'b0001));
    for (int k = 0; k < 8 && q.size() > 0; k++) cyc('0, 0, 1, '1);
    // in-order response steering
    cyc(4'b0010, 1, 0, '0);
    cyc(4'b1000, 1, 0, '0);
    cyc(4'b0010, 1, 0, '0);
    cyc('0, 0, 1, '1); chk("t4_r1", W'(last_resp_v), W'(4'b0010));
    cyc('0, 0, 1, 4'b0111); chk("t4_r3_stall_v", W'(last_resp_v), W'(4'b1000)); chk("t4_r3_stall_rdy", W'(last_resp_rdy), '0);
    cyc('0, 0, 1, '1); chk("t4_r3", W'(last_resp_v), W'(4'b1000));
    cyc('0, 0, 1, '1); chk("t4_r1b", W'(last_resp_v), W'(4'b0010));
    // simultaneous enqueue and dequeue
    cyc(4'b0001, 1, 0, '0);
    cyc(4'b0010, 1, 0, '0);
    cyc(4'b0100, 1, 1, '1); chk("t5_n_before", W'(last_out), W'(2));
    cyc('0, 0, 0, '0); chk("t5_n_after", W'(last_out), W'(2));
    cyc('0, 0, 1, '1); chk("t5_order1", W'(last_resp_v), W'(4'b0010));
    cyc('0, 0, 1, '1); chk("t5_order2", W'(last_resp_v), W'(4'b0100));
    for (int k = 0; k < 400; k++)
      cyc(N'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
    for (int k = 0; k < 8 && q.size() > 0; k++) cyc('0, 0, 1, '1);
    // asynchronous reset with commands in flight
    cyc(4'b0001, 1, 0, '0);
    cyc(4'b0010, 1, 0, '0);
    @(negedge clk_i);
    cmd_v_i = '1;
    cmd_ready_and_i = 1'b1;
    resp_v_i = 1'b0;
    resp_i = '0;
    #2 reset_n_i = 1'b0;
    #1 chk_reset_outputs("t6_async");
    q.delete();
    prio = 0;
    lock = -1;
    cmd_v_i = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    resp_v_i = 1'b1;
    resp_ready_and_i = '1;
    #1;
    chk("t6_empty_rdy", W'(resp_ready_and_o), '0);
    chk("t6_empty_v", W'(resp_v_o), '0);
    #1 resp_v_i = 1'b0;
    cyc('1, 1, 0, '0); chk("t6_g0", W'(last_rdy), W'(4'b0001));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
